// File: rtl/fmap_read_sequencer_pkg.sv
// ============================================================================
// Module  : fmap_rd_defs (package)
// Purpose : Shared FSM encodings and bus width defaults for the fmap read path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fmap_rd_defs;

  localparam int FMAP_DATA_W     = 8;
  localparam int FMAP_BANK_W     = 6;
  localparam int FMAP_ADDR_W     = 11;
  localparam int FMAP_BYTE_CNT_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fmap_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/fmap_read_sequencer_if.sv
// ============================================================================
// Module  : fmap_read_sequencer_if
// Purpose : Buffer read port plus valid/ready byte stream toward the FC stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fmap_read_sequencer_if
  import fmap_rd_defs::*;
#(
  parameter int DATA_W = FMAP_DATA_W,
  parameter int BANK_W = FMAP_BANK_W,
  parameter int ADDR_W = FMAP_ADDR_W
);

  logic              rd_en;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_rdy;
  logic              out_last;

  modport master (
    output rd_en, rd_bank, rd_addr, out_data, out_vld, out_last,
    input  rd_data, out_rdy
  );

  modport slave (
    input  rd_en, rd_bank, rd_addr, out_data, out_vld, out_last,
    output rd_data, out_rdy
  );

endinterface

`default_nettype wire

// File: rtl/fmap_read_sequencer_skid_fifo.sv
// ============================================================================
// Module  : fmap_skid_fifo
// Purpose : Synchronous first-word-fall-through FIFO with occupancy count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fmap_skid_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/fmap_read_sequencer.sv
// ============================================================================
// Module  : fmap_read_sequencer
// Purpose : Walks banks x words of the fmap buffer and streams bytes to FC.
//           Optional frame checksum when FMAP_RD_CHKSUM_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fmap_read_sequencer
  import fmap_rd_defs::*;
#(
  parameter int DATA_W = FMAP_DATA_W,
  parameter int BANK_W = FMAP_BANK_W,
  parameter int ADDR_W = FMAP_ADDR_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic                   clk,
  input  logic                   global_rst,
  input  logic                   start,
  input  logic [BANK_W-1:0]      cfg_banks,
  input  logic [ADDR_W-1:0]      cfg_words,
  fmap_read_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            chksum
);

  localparam int CNT_W  = $clog2(FIFO_D) + 1;
  localparam int BYTE_W = FMAP_BYTE_CNT_W;

  fmap_rd_state_t    state;
  fmap_rd_state_t    state_nxt;

  logic [BANK_W-1:0] banks_q;
  logic [ADDR_W-1:0] words_q;
  logic [BANK_W-1:0] bank_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [BYTE_W-1:0] total_q;
  logic [BYTE_W-1:0] byte_cnt;
  logic [RD_LAT-1:0] vld_sr;

  logic [CNT_W:0]    inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              credit_ok;
  logic              issue;
  logic              accept;
  logic              cfg_zero;
  logic              last_addr;
  logic              last_bank;
  logic              xfer;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {{CNT_W{1'b0}}, vld_sr[i]};
    end
  end

  // Reads in flight already own a FIFO slot, so they count against the credit.
  assign credit_ok = (({1'b0, fifo_count} + inflight) < (CNT_W+1)'(FIFO_D));
  assign issue     = (state == ST_ISSUE) && credit_ok;
  assign accept    = (state == ST_IDLE) && start;
  assign cfg_zero  = (cfg_banks == '0) || (cfg_words == '0);
  assign last_addr = (addr_cnt == words_q - ADDR_W'(1));
  assign last_bank = (bank_cnt == banks_q - BANK_W'(1));
  assign xfer      = bus.out_vld && bus.out_rdy;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = cfg_zero ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue && last_addr && last_bank) state_nxt = ST_DRAIN;
      ST_DRAIN: if (xfer && bus.out_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      banks_q  <= '0;
      words_q  <= '0;
      bank_cnt <= '0;
      addr_cnt <= '0;
      total_q  <= '0;
      byte_cnt <= '0;
      vld_sr   <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
      if (accept) begin
        banks_q  <= cfg_banks;
        words_q  <= cfg_words;
        bank_cnt <= '0;
        addr_cnt <= '0;
        byte_cnt <= '0;
        total_q  <= BYTE_W'(cfg_banks) * BYTE_W'(cfg_words);
      end else begin
        if (issue) begin
          if (last_addr) begin
            addr_cnt <= '0;
            bank_cnt <= last_bank ? '0 : bank_cnt + BANK_W'(1);
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
          end
        end
        if (xfer) byte_cnt <= byte_cnt + BYTE_W'(1);
      end
    end
  end

  fmap_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst       (global_rst),
    .push      (vld_sr[RD_LAT-1]),
    .push_data (bus.rd_data),
    .pop       (xfer),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.rd_en    = issue;
  assign bus.rd_bank  = bank_cnt;
  assign bus.rd_addr  = addr_cnt;
  assign bus.out_vld  = !fifo_empty;
  assign bus.out_data = fifo_head;
  assign bus.out_last = !fifo_empty && ((byte_cnt + BYTE_W'(1)) == total_q);

  assign busy = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

`ifdef FMAP_RD_CHKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst)  sum_q <= '0;
    else if (accept) sum_q <= '0;
    else if (xfer)   sum_q <= sum_q + 16'(bus.out_data);
  end

  assign chksum = sum_q;
`else
  assign chksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fmap_read_sequencer.sv
// ============================================================================
// Module  : tb_fmap_read_sequencer
// Purpose : Vector-table and randomized-backpressure bench for the fmap reader.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fmap_read_sequencer;
  import fmap_rd_defs::*;

  localparam int DATA_W = 8;
  localparam int BANK_W = 6;
  localparam int ADDR_W = 11;
  localparam int RD_LAT = 1;
  localparam int FIFO_D = 4;

  logic              clk = 1'b0;
  logic              global_rst = 1'b1;
  logic              start = 1'b0;
  logic [BANK_W-1:0] cfg_banks = '0;
  logic [ADDR_W-1:0] cfg_words = '0;
  logic              busy;
  logic              done;
  logic [15:0]       chksum;

  fmap_read_sequencer_if #(.DATA_W(DATA_W), .BANK_W(BANK_W), .ADDR_W(ADDR_W)) bus ();

  fmap_read_sequencer #(
    .DATA_W(DATA_W), .BANK_W(BANK_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
  ) dut (
    .clk        (clk),
    .global_rst (global_rst),
    .start      (start),
    .cfg_banks  (cfg_banks),
    .cfg_words  (cfg_words),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .chksum     (chksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int salt = 0;
  bit sp_mode = 1'b0;
  int rdy_mode = 0;

  int rd_count, xfer_count, done_count, outstanding, max_out;
  int first_rd_cyc, last_rd_cyc, last_xfer_cyc, done_cyc, start_cyc;
  int sum_model;
  int iss_q[$];
  logic [7:0] dat_q[$];
  int e_iss;
  logic [7:0] e_byte;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Buffer contents: a fixed pattern per frame, or the checksum example bytes.
  function automatic logic [7:0] buf_byte(input int b, input int a);
    logic [7:0] sp [4];
    sp = '{8'hFF, 8'hFF, 8'h01, 8'h02};
    if (sp_mode) return sp[a % 4];
    return 8'(((b * 41) + (a * 7) + salt) ^ (a >> 3));
  endfunction

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= buf_byte(int'(bus.rd_bank), int'(bus.rd_addr));
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_rdy = 1'b1;
      1:       bus.out_rdy = ~bus.out_rdy;
      2:       bus.out_rdy = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!global_rst) begin
      if (bus.rd_en) begin
        rd_count++;
        outstanding++;
        if (rd_count == 1) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        if (iss_q.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e_iss = iss_q.pop_front();
          chk("rd_bank_addr", 64'({bus.rd_bank, bus.rd_addr}), 64'(e_iss));
        end
      end
      if (bus.out_vld && bus.out_rdy) begin
        xfer_count++;
        outstanding--;
        last_xfer_cyc = cyc;
        if (dat_q.size() == 0) chk("byte_extra", 1, 0);
        else begin
          e_byte = dat_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e_byte));
          chk("out_last", 64'(bus.out_last), 64'(dat_q.size() == 0));
          sum_model += int'(e_byte);
        end
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic begin_frame(input int b, input int w, input int sl, input bit sp);
    salt    = sl;
    sp_mode = sp;
    iss_q.delete();
    dat_q.delete();
    for (int bi = 0; bi < b; bi++) begin
      for (int ai = 0; ai < w; ai++) begin
        iss_q.push_back(bi * 2048 + ai);
        dat_q.push_back(buf_byte(bi, ai));
      end
    end
    rd_count = 0; xfer_count = 0; done_count = 0; outstanding = 0; max_out = 0;
    sum_model = 0; first_rd_cyc = 0; last_rd_cyc = 0; last_xfer_cyc = 0; done_cyc = 0;
    @(posedge clk); #1;
    cfg_banks = BANK_W'(b);
    cfg_words = ADDR_W'(w);
    start = 1'b1;
    @(posedge clk);
    start_cyc = cyc;
    #1;
    start = 1'b0;
    cfg_banks = BANK_W'($urandom);
    cfg_words = ADDR_W'($urandom);
  endtask

  task automatic finish_frame(input int n, input int mode);
    int k;
    k = 0;
    while (done_count == 0 && k < n * 6 + 60) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", 64'(done_count > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_count), 1);
    chk("busy_after", 64'(busy), 0);
    chk("bytes", 64'(xfer_count), 64'(n));
    chk("reads", 64'(rd_count), 64'(n));
    chk("outstanding_le_fifo", 64'(max_out <= FIFO_D), 1);
    if (n > 0) begin
      chk("first_rd_latency", 64'(first_rd_cyc - start_cyc), 1);
      chk("done_after_last", 64'(done_cyc - last_xfer_cyc), 1);
      if (mode == 0) chk("full_throughput", 64'(last_rd_cyc - first_rd_cyc), 64'(n - 1));
    end else begin
      chk("zero_done_latency", 64'((done_cyc - start_cyc) <= 2), 1);
    end
`ifdef FMAP_RD_CHKSUM_EN
    chk("chksum", 64'(chksum), 64'(sum_model & 16'hFFFF));
`endif
  endtask

  typedef struct {
    int banks;
    int words;
    int mode;
    int salt;
    bit sp;
    int exp_bytes;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    vecs[0] = '{2,   3,    0, 5,  1'b0, 6};
    vecs[1] = '{8,   16,   1, 9,  1'b0, 128};
    vecs[2] = '{1,   1,    0, 3,  1'b0, 1};
    vecs[3] = '{3,   0,    0, 1,  1'b0, 0};
    vecs[4] = '{0,   5,    0, 1,  1'b0, 0};
    vecs[5] = '{5,   7,    2, 17, 1'b0, 35};
    vecs[6] = '{4,   4,    3, 23, 1'b0, 16};
    vecs[7] = '{63,  3,    2, 31, 1'b0, 189};
    vecs[8] = '{2,   2047, 0, 77, 1'b0, 4094};
    vecs[9] = '{1,   4,    0, 0,  1'b1, 4};

    bus.rd_data = '0;
    bus.out_rdy = 1'b0;
    #12;
    chk("reset_outputs", 64'({bus.rd_en, bus.out_vld, bus.out_last, busy, done,
                              bus.rd_bank, bus.rd_addr}), 0);
    chk("reset_chksum", 64'(chksum), 0);
    @(posedge clk); #1;
    global_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        // Abort a 128-byte frame part way through.
        rdy_mode = 0;
        begin_frame(8, 16, 41, 1'b0);
        k = 0;
        while (xfer_count < 50 && k < 500) begin
          @(posedge clk);
          k++;
        end
        chk("reach_byte50", 64'(xfer_count >= 50), 1);
        @(negedge clk); #2;
        global_rst = 1'b1;
        #1;
        chk("abort_outputs", 64'({bus.rd_en, bus.out_vld, bus.out_last, busy, done,
                                  bus.rd_bank, bus.rd_addr}), 0);
        done_count = 0;
        repeat (3) @(posedge clk);
        #1;
        global_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", 64'({done, busy}), 0);
      end

      if (vecs[i].mode == 3) begin
        rdy_mode = 3;
        bus.out_rdy = 1'b0;
      end else begin
        rdy_mode = vecs[i].mode;
      end
      begin_frame(vecs[i].banks, vecs[i].words, vecs[i].salt, vecs[i].sp);
      if (vecs[i].mode == 3) begin
        repeat (20) @(posedge clk);
        #1;
        chk("stall_reads", 64'(rd_count), 64'(FIFO_D));
        chk("stall_backlog", 64'(max_out), 64'(FIFO_D));
        chk("stall_vld", 64'(bus.out_vld), 1);
        rdy_mode = 0;
      end
      finish_frame(vecs[i].exp_bytes, vecs[i].mode);
`ifdef FMAP_RD_CHKSUM_EN
      if (vecs[i].sp) chk("chksum_example", 64'(chksum), 64'h0201);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
